// File: rtl/pong_pkg.sv
// Shared encodings and timing constants for the breakout game controller.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_NEWGAME = 3'd0,
    ST_PLAY    = 3'd1,
    ST_NEWBALL = 3'd2,
    ST_OVER    = 3'd3,
    ST_WIN     = 3'd4
  } state_t;

  localparam int DELAY_TICKS = 120;
  localparam int REFR_Y      = 481;
  localparam int MAX_X       = 640;
  localparam int MAX_Y       = 480;

endpackage

// File: rtl/breakout_ctrl_bcd.sv
// Two-digit BCD score counter; clr wins over inc, saturates at 99.
module bcd_score_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] d1,
  output logic [3:0] d0
);

  logic at_max;
  assign at_max = (d1 == 4'd9) && (d0 == 4'd9);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      d1 <= '0;
      d0 <= '0;
    end else if (inc && !at_max) begin
      if (d0 == 4'd9) begin
        d0 <= '0;
        d1 <= d1 + 4'd1;
      end else begin
        d0 <= d0 + 4'd1;
      end
    end
  end

endmodule

// File: rtl/breakout_ctrl.sv
// Game sequencer downstream of the breakout graphics engine: edge-detects
// hit/miss, keeps score/balls/bricks and freezes the playfield outside PLAY.
module breakout_ctrl #(
  parameter int NUM_BRICKS  = 2,
  parameter int NUM_BALLS   = 3,
  parameter int DELAY_TICKS = pong_pkg::DELAY_TICKS,
  parameter int REFR_Y      = pong_pkg::REFR_Y
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [1:0] balls_left,
  output logic [2:0] game_state
);
  import pong_pkg::*;

  localparam int BW = $clog2(NUM_BRICKS + 1);

  state_t          state_q, state_d;
  logic            hit_q, miss_q, hit_ev, miss_ev;
  logic [6:0]      timer_q;
  logic [1:0]      balls_q;
  logic [BW-1:0]   bricks_q;
  logic            refr_tick, press, in_play, win_ev, clr, still_d, timed_entry;

  assign refr_tick = (pix_y == 10'(REFR_Y)) && (pix_x == 10'd0);
  assign press     = |btn;
  assign in_play   = (state_q == ST_PLAY);
  assign win_ev    = hit_ev && (bricks_q == BW'(NUM_BRICKS - 1));
  // Reinit on the entry edge so NEWGAME already shows a clean board.
  assign clr       = (state_d == ST_NEWGAME);
  assign timed_entry = (state_d != state_q) &&
                       (state_d == ST_NEWBALL || state_d == ST_OVER || state_d == ST_WIN);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_NEWGAME;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NEWGAME: if (press) state_d = ST_PLAY;
      ST_PLAY: begin
        if (win_ev)       state_d = ST_WIN;
        else if (miss_ev) state_d = (balls_q == 2'd1) ? ST_OVER : ST_NEWBALL;
      end
      ST_NEWBALL: if (timer_q == 7'd0 && press) state_d = ST_PLAY;
      ST_OVER, ST_WIN: if (timer_q == 7'd0) state_d = ST_NEWGAME;
      default: state_d = ST_NEWGAME;
    endcase
  end

  // Output logic
  always_comb begin
    still_d    = (state_d != ST_PLAY);
    game_state = state_q;
    balls_left = balls_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) gra_still <= 1'b1;
    else        gra_still <= still_d;
  end

  // Events are registered (one cycle) and only captured while playing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      hit_ev  <= 1'b0;
      miss_ev <= 1'b0;
    end else begin
      hit_q   <= hit;
      miss_q  <= miss;
      hit_ev  <= hit & ~hit_q & in_play;
      miss_ev <= miss & ~miss_q & in_play;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)                 timer_q <= '0;
    else if (timed_entry)       timer_q <= 7'(DELAY_TICKS);
    else if (refr_tick && timer_q != 7'd0) timer_q <= timer_q - 7'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      bricks_q <= '0;
      balls_q  <= 2'(NUM_BALLS);
    end else if (in_play) begin
      if (hit_ev)            bricks_q <= bricks_q + BW'(1);
      if (miss_ev && !win_ev) balls_q <= balls_q - 2'd1;
    end
  end

  bcd_score_cnt u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (in_play & hit_ev),
    .d1    (score_d1),
    .d0    (score_d0)
  );

endmodule

// File: tb/tb_breakout_ctrl.sv
// Scoreboard bench: expected snapshots queued with stimulus, popped at check points.
module tb_breakout_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] btn = '0;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic       hit = 1'b0, miss = 1'b0, hit_s = 1'b0;

  logic       still, still_s;
  logic [3:0] d1, d0, d1_s, d0_s;
  logic [1:0] balls, balls_s;
  logic [2:0] st, st_s;

  always #5 clk = ~clk;

  breakout_ctrl dut (
    .clk(clk), .reset(reset), .btn(btn), .pix_x(pix_x), .pix_y(pix_y),
    .hit(hit), .miss(miss), .gra_still(still), .score_d1(d1), .score_d0(d0),
    .balls_left(balls), .game_state(st)
  );

  // Deep-brick instance so the score can be driven to saturation without a WIN.
  breakout_ctrl #(.NUM_BRICKS(120)) dut_sat (
    .clk(clk), .reset(reset), .btn(btn), .pix_x(pix_x), .pix_y(pix_y),
    .hit(hit_s), .miss(miss), .gra_still(still_s), .score_d1(d1_s), .score_d0(d0_s),
    .balls_left(balls_s), .game_state(st_s)
  );

  localparam logic [2:0] NG = 3'd0, PL = 3'd1, NB = 3'd2, OV = 3'd3, WN = 3'd4;

  typedef struct {
    string       name;
    bit          sat;
    logic [13:0] v;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [13:0] got;
  int          n_run = 0, n_fail = 0;

  wire [13:0] snap   = {st, still, d1, d0, balls};
  wire [13:0] snap_s = {st_s, still_s, d1_s, d0_s, balls_s};

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(string name, bit sat, logic [2:0] s, logic g,
                      logic [3:0] t, logic [3:0] u, logic [1:0] b);
    exp_t x;
    x.name = name; x.sat = sat; x.v = {s, g, t, u, b};
    sb.push_back(x);
  endtask

  task automatic press_btn(logic [4:0] v);
    btn = v; step(); btn = '0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1; step(); hit = 1'b0; step();
  endtask

  task automatic pulse_hit_s();
    hit_s = 1'b1; step(); hit_s = 1'b0; step();
  endtask

  task automatic pulse_miss();
    miss = 1'b1; step(); miss = 1'b0; step();
  endtask

  task automatic ticks(int n);
    pix_y = 10'd481; pix_x = 10'd0;
    step(n);
    pix_y = 10'd0; pix_x = 10'd5;
  endtask

  task automatic test_reset();
    push("reset_init", 0, NG, 1, 0, 0, 3);
    push("reset_init_sat", 1, NG, 1, 0, 0, 3);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = e.sat ? snap_s : snap; n_run++;
      if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
    end
    press_btn(5'h01);
    repeat (5) pulse_hit_s();
    pulse_hit();
    push("pre_reset_main", 0, PL, 0, 0, 1, 3);
    push("pre_reset_sat", 1, PL, 0, 0, 5, 3);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = e.sat ? snap_s : snap; n_run++;
      if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
    end
    reset = 1'b0; hit = 1'b1;
    step();
    push("mid_reset_main", 0, NG, 1, 0, 0, 3);
    push("mid_reset_sat", 1, NG, 1, 0, 0, 3);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = e.sat ? snap_s : snap; n_run++;
      if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
    end
    step(); hit = 1'b0; reset = 1'b1; step();
  endtask

  task automatic test_hit_level();
    press_btn(5'h10);
    push("btn_to_play", 0, PL, 0, 0, 0, 3);
    e = sb.pop_front(); got = snap; n_run++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
    hit = 1'b1; step(3); hit = 1'b0; step();
    push("hit_level_once", 0, PL, 0, 0, 1, 3);
    e = sb.pop_front(); got = snap; n_run++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
  endtask

  task automatic test_win();
    pulse_hit();
    push("win_entry", 0, WN, 1, 0, 2, 3);
    e = sb.pop_front(); got = snap; n_run++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
    ticks(119);
    push("win_hold_119", 0, WN, 1, 0, 2, 3);
    e = sb.pop_front(); got = snap; n_run++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
    ticks(1); step();
    push("win_to_newgame", 0, NG, 1, 0, 0, 3);
    e = sb.pop_front(); got = snap; n_run++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
  endtask

  task automatic test_miss();
    press_btn(5'h02);
    for (int b = 3; b >= 1; b--) begin
      pulse_miss();
      if (b > 1) push($sformatf("miss_newball_%0d", b), 0, NB, 1, 0, 0, 2'(b - 1));
      else       push("miss_over", 0, OV, 1, 0, 0, 0);
      e = sb.pop_front(); got = snap; n_run++;
      if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
      ticks(120);
      if (b > 1) begin
        press_btn(5'h04);
        push($sformatf("resume_play_%0d", b), 0, PL, 0, 0, 0, 2'(b - 1));
        e = sb.pop_front(); got = snap; n_run++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
      end
    end
    step();
    push("over_to_newgame", 0, NG, 1, 0, 0, 3);
    e = sb.pop_front(); got = snap; n_run++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
  endtask

  task automatic test_newball_early();
    press_btn(5'h08);
    pulse_miss();
    ticks(60);
    press_btn(5'h01); step();
    push("early_btn_ignored", 0, NB, 1, 0, 0, 2);
    e = sb.pop_front(); got = snap; n_run++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
    ticks(60);
    press_btn(5'h01);
    push("late_btn_play", 0, PL, 0, 0, 0, 2);
    e = sb.pop_front(); got = snap; n_run++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
  endtask

  task automatic test_same_cycle();
    pulse_hit();
    hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0; step();
    push("hit_miss_win", 0, WN, 1, 0, 2, 2);
    e = sb.pop_front(); got = snap; n_run++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
    ticks(120); step();
  endtask

  task automatic test_saturate();
    reset = 1'b0; step(); reset = 1'b1; step();
    press_btn(5'h01);
    repeat (99) pulse_hit_s();
    push("score_99", 1, PL, 0, 9, 9, 3);
    e = sb.pop_front(); got = snap_s; n_run++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
    pulse_hit_s();
    push("score_sat_99", 1, PL, 0, 9, 9, 3);
    e = sb.pop_front(); got = snap_s; n_run++;
    if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h exp %h", e.name, got, e.v); end
  endtask

  initial begin
    step(2);
    reset = 1'b1;
    step();
    test_reset();
    test_hit_level();
    test_win();
    test_miss();
    test_newball_early();
    test_same_cycle();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
